// File: rtl/netdma_slot_alloc_pkg.sv
// Shared constants and helpers for the netdma descriptor slot allocator.
// Slot count is always a power of two, derived from the index width.
package netdma_slot_alloc_pkg;

    localparam int unsigned DEFAULT_RANGE = 32'd4;

    function automatic int unsigned slots_f(input int unsigned range);
        return 32'd1 << range;
    endfunction

endpackage

// File: rtl/netdma_slot_alloc_if.sv
// Allocation offer/ack and release handshake between the slot allocator (master)
// and the descriptor writer / completion path (slave).
interface netdma_slot_alloc_if #(
    parameter int unsigned RANGE = 32'd4
) ();

    logic             alloc_valid;
    logic [RANGE-1:0] alloc_idx;
    logic             alloc_ack;
    logic             rel_valid;
    logic [RANGE-1:0] rel_idx;

    modport master (
        output alloc_valid,
        output alloc_idx,
        input  alloc_ack,
        input  rel_valid,
        input  rel_idx
    );

    modport slave (
        input  alloc_valid,
        input  alloc_idx,
        output alloc_ack,
        output rel_valid,
        output rel_idx
    );

endinterface

// File: rtl/netdma_decoder.sv
// Binary index to one-hot slot enable decoder.
module netdma_decoder #(
    parameter int unsigned RANGE = 32'd4
) (
    input  logic [RANGE-1:0]        idx_i,
    output logic [(1<<RANGE)-1:0]   onehot_o
);

    // Single set bit at the indexed position
    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/netdma_slot_alloc_rr_find_free.sv
// Circular first-free search: lowest free slot at or after start, wrapping around.
module netdma_slot_alloc_rr_find_free
    import netdma_slot_alloc_pkg::*;
#(
    parameter int unsigned RANGE = DEFAULT_RANGE
) (
    input  logic [(1<<RANGE)-1:0] mask_i,
    input  logic [RANGE-1:0]      start_i,
    output logic [RANGE-1:0]      idx_o,
    output logic                  found_o
);

    localparam int unsigned N = slots_f(RANGE);

    logic [2*N-1:0]   free_dbl_s;
    logic [N-1:0]     win_s;
    logic [RANGE-1:0] off_s;

    // Doubling the free map turns the circular scan into a plain shift plus priority encode
    always_comb begin
        free_dbl_s = {~mask_i, ~mask_i};
        win_s      = N'(free_dbl_s >> start_i);
        off_s      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (win_s[k]) begin
                off_s = RANGE'(k);
            end else begin
                off_s = off_s;
            end
        end
        idx_o   = start_i + off_s;
        found_o = |win_s;
    end

endmodule

// File: rtl/netdma_slot_alloc.sv
// Round-robin allocator for 2**RANGE netdma descriptor slots with release tracking.
// Every output is registered; the offer for the next cycle is computed from next-state busy.
module netdma_slot_alloc
    import netdma_slot_alloc_pkg::*;
#(
    parameter int unsigned RANGE = DEFAULT_RANGE
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    netdma_slot_alloc_if.master    bus_if,
    output logic [(1<<RANGE)-1:0]  busy_o,
    output logic [RANGE:0]         used_cnt_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   err_rel_o
);

    localparam int unsigned N = slots_f(RANGE);

    typedef logic [RANGE-1:0] slot_idx_t;
    typedef logic [N-1:0]     slot_mask_t;
    typedef logic [RANGE:0]   slot_cnt_t;

    slot_mask_t busy_q, busy_d;
    slot_idx_t  ptr_q, ptr_d;
    slot_cnt_t  cnt_q, cnt_d;
    logic       offer_vld_q;
    slot_idx_t  offer_idx_q;
    logic       full_q;
    logic       empty_q;
    logic       err_q;

    logic       acc_s;
    logic       rel_ok_s;
    logic       rel_err_s;
    slot_mask_t oh_alloc_s;
    slot_mask_t oh_rel_s;
    slot_mask_t set_mask_s;
    slot_mask_t clr_mask_s;
    slot_idx_t  ff_idx_s;
    logic       ff_found_s;

    netdma_decoder #(.RANGE(RANGE)) u_dec_alloc (
        .idx_i    (offer_idx_q),
        .onehot_o (oh_alloc_s)
    );

    netdma_decoder #(.RANGE(RANGE)) u_dec_rel (
        .idx_i    (bus_if.rel_idx),
        .onehot_o (oh_rel_s)
    );

    netdma_slot_alloc_rr_find_free #(.RANGE(RANGE)) u_find_free (
        .mask_i  (busy_d),
        .start_i (ptr_d),
        .idx_o   (ff_idx_s),
        .found_o (ff_found_s)
    );

    // Next-state for busy map, round-robin pointer and occupancy count
    always_comb begin
        acc_s     = bus_if.alloc_ack & offer_vld_q;
        rel_ok_s  = bus_if.rel_valid & busy_q[bus_if.rel_idx];
        rel_err_s = bus_if.rel_valid & ~busy_q[bus_if.rel_idx];

        if (acc_s) begin
            set_mask_s = oh_alloc_s;
            ptr_d      = offer_idx_q + RANGE'(1);
        end else begin
            set_mask_s = '0;
            ptr_d      = ptr_q;
        end

        // A rejected release never touches the map or the count
        if (rel_ok_s) begin
            clr_mask_s = oh_rel_s;
        end else begin
            clr_mask_s = '0;
        end

        busy_d = (busy_q | set_mask_s) & ~clr_mask_s;
        cnt_d  = cnt_q + {{RANGE{1'b0}}, acc_s} - {{RANGE{1'b0}}, rel_ok_s};
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q      <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            offer_vld_q <= 1'b0;
            offer_idx_q <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            offer_vld_q <= ff_found_s;
            offer_idx_q <= ff_idx_s;
            full_q      <= (cnt_d == slot_cnt_t'(N));
            empty_q     <= (cnt_d == slot_cnt_t'(0));
            err_q       <= rel_err_s;
        end
    end

    assign bus_if.alloc_valid = offer_vld_q;
    assign bus_if.alloc_idx   = offer_idx_q;
    assign busy_o             = busy_q;
    assign used_cnt_o         = cnt_q;
    assign full_o             = full_q;
    assign empty_o            = empty_q;
    assign err_rel_o          = err_q;

endmodule
